// File: rtl/mspu_avmm_pkg.sv
// Shared types and constants for the mspe Avalon-MM data ports and their responder.
// Imported by both the responder and the mspe master wrapper.
package mspu_avmm_pkg;

  localparam int DATA_W  = 512;
  localparam int BE_W    = 64;
  localparam int BURST_W = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RBURST = 2'd1,
    WBURST = 2'd2
  } state_t;

  // Effective beat count: zero means one beat, oversize requests clamp to max_b.
  function automatic logic [BURST_W-1:0] eff_burst(input logic [BURST_W-1:0] bc,
                                                   input logic [BURST_W-1:0] max_b);
    if (bc == '0) return BURST_W'(1);
    if (bc > max_b) return max_b;
    return bc;
  endfunction

endpackage

// File: rtl/bram_be_512.sv
// Simple dual-port 512-bit RAM with 64 byte lanes; registered read address and
// registered output give a two-cycle read latency. Contents survive reset.
module bram_be_512
  import mspu_avmm_pkg::*;
#(
  parameter int DEPTH = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [DEPTH-1:0]  wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [BE_W-1:0]   wr_be,
  input  logic              rd_en,
  input  logic [DEPTH-1:0]  rd_addr,
  input  logic              dout_en,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [2**DEPTH];
  logic [DEPTH-1:0]  rd_addr_q;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < BE_W; i++) begin
        if (wr_be[i]) mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  // Only the read pipeline registers are reset; the array itself is not.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_addr_q <= '0;
      rd_data   <= '0;
    end else begin
      if (rd_en)   rd_addr_q <= rd_addr;
      if (dout_en) rd_data   <= mem[rd_addr_q];
    end
  end

endmodule

// File: rtl/avmm_burst_responder.sv
// Avalon-MM pipelined burst slave over a byte-enabled RAM, used as the DRAM
// stand-in for the mspe data ports. Tracks beat counts and sticky protocol flags.
module avmm_burst_responder
  import mspu_avmm_pkg::*;
#(
  parameter int DEPTH     = 10,
  parameter int MAX_BURST = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [63:0]  s_address,
  input  logic [2:0]   s_burstcount,
  input  logic         s_read,
  input  logic         s_write,
  input  logic [511:0] s_writedata,
  input  logic [63:0]  s_byteenable,
  output logic         s_waitrequest,
  output logic [511:0] s_readdata,
  output logic         s_readdatavalid,
  input  logic         cnt_clear,
  output logic [63:0]  rd_beats,
  output logic [63:0]  wr_beats,
  output logic         addr_wrap,
  output logic         proto_err,
  output logic [1:0]   dbg_state
);

  // Handshake: a command (or write beat) is accepted in any cycle where s_read or
  // s_write is high and s_waitrequest is low; read data has no backpressure and
  // arrives in issue order, one beat per cycle s_readdatavalid is high.

  localparam logic [BURST_W-1:0] MAX_B = BURST_W'(MAX_BURST);

  state_t             state, state_n;
  logic [DEPTH-1:0]   addr_q, addr_n;
  logic [BURST_W-1:0] rem_q, rem_n;
  logic [BURST_W-1:0] n_beats;
  logic [DEPTH-1:0]   base;
  logic               busy_wait;
  logic               rd_en, wr_en;
  logic [DEPTH-1:0]   rd_addr, wr_addr;
  logic               rd_v1;
  logic               err_now, wrap_now;

  assign base          = s_address[DEPTH-1:0];
  assign n_beats       = eff_burst(s_burstcount, MAX_B);
  assign s_waitrequest = reset | busy_wait;
  assign dbg_state     = state;

  always_comb begin
    state_n   = state;
    addr_n    = addr_q;
    rem_n     = rem_q;
    busy_wait = 1'b0;
    rd_en     = 1'b0;
    wr_en     = 1'b0;
    rd_addr   = addr_q;
    wr_addr   = addr_q;
    err_now   = 1'b0;
    wrap_now  = 1'b0;
    if (!reset) begin
      case (state)
        IDLE: begin
          // A write takes priority; a simultaneous read is dropped and flagged.
          if (s_write) begin
            wr_en    = 1'b1;
            wr_addr  = base;
            wrap_now = |s_address[63:DEPTH];
            err_now  = s_read || (s_burstcount > MAX_B);
            if (n_beats > BURST_W'(1)) begin
              addr_n  = base + DEPTH'(1);
              rem_n   = n_beats - BURST_W'(1);
              state_n = WBURST;
            end
          end else if (s_read) begin
            rd_en    = 1'b1;
            rd_addr  = base;
            wrap_now = |s_address[63:DEPTH];
            err_now  = s_burstcount > MAX_B;
            if (n_beats > BURST_W'(1)) begin
              addr_n  = base + DEPTH'(1);
              rem_n   = n_beats - BURST_W'(1);
              state_n = RBURST;
            end
          end
        end
        RBURST: begin
          busy_wait = 1'b1;
          rd_en     = 1'b1;
          addr_n    = addr_q + DEPTH'(1);
          rem_n     = rem_q - BURST_W'(1);
          if (rem_q == BURST_W'(1)) state_n = IDLE;
        end
        WBURST: begin
          err_now = s_read;
          if (s_write) begin
            wr_en  = 1'b1;
            addr_n = addr_q + DEPTH'(1);
            rem_n  = rem_q - BURST_W'(1);
            if (rem_q == BURST_W'(1)) state_n = IDLE;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      addr_q <= '0;
      rem_q  <= '0;
    end else begin
      state  <= state_n;
      addr_q <= addr_n;
      rem_q  <= rem_n;
    end
  end

  // Valid pipeline mirrors the RAM's two register stages; reset flushes it.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_v1           <= 1'b0;
      s_readdatavalid <= 1'b0;
    end else begin
      rd_v1           <= rd_en;
      s_readdatavalid <= rd_v1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || cnt_clear) begin
      rd_beats  <= '0;
      wr_beats  <= '0;
      addr_wrap <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      if (s_readdatavalid) rd_beats <= rd_beats + 64'd1;
      if (wr_en)           wr_beats <= wr_beats + 64'd1;
      if (err_now)         proto_err <= 1'b1;
      if (wrap_now)        addr_wrap <= 1'b1;
    end
  end

  bram_be_512 #(
    .DEPTH(DEPTH)
  ) u_ram (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (s_writedata),
    .wr_be   (s_byteenable),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .dout_en (rd_v1),
    .rd_data (s_readdata)
  );

endmodule

// File: tb/tb_avmm_burst_responder.sv
// Self-checking bench for avmm_burst_responder: driver tasks, a RAM model and a
// read-data scoreboard keyed by expected return cycle.
module tb_avmm_burst_responder;
  import mspu_avmm_pkg::*;

  localparam int DEPTH = 10;
  localparam int WORDS = 1 << DEPTH;
  localparam int MAXB  = 4;

  logic         clk;
  logic         reset;
  logic [63:0]  s_address;
  logic [2:0]   s_burstcount;
  logic         s_read;
  logic         s_write;
  logic [511:0] s_writedata;
  logic [63:0]  s_byteenable;
  logic         s_waitrequest;
  logic [511:0] s_readdata;
  logic         s_readdatavalid;
  logic         cnt_clear;
  logic [63:0]  rd_beats;
  logic [63:0]  wr_beats;
  logic         addr_wrap;
  logic         proto_err;
  logic [1:0]   dbg_state;

  avmm_burst_responder #(
    .DEPTH     (DEPTH),
    .MAX_BURST (MAXB)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .s_address       (s_address),
    .s_burstcount    (s_burstcount),
    .s_read          (s_read),
    .s_write         (s_write),
    .s_writedata     (s_writedata),
    .s_byteenable    (s_byteenable),
    .s_waitrequest   (s_waitrequest),
    .s_readdata      (s_readdata),
    .s_readdatavalid (s_readdatavalid),
    .cnt_clear       (cnt_clear),
    .rd_beats        (rd_beats),
    .wr_beats        (wr_beats),
    .addr_wrap       (addr_wrap),
    .proto_err       (proto_err),
    .dbg_state       (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [511:0] exp_q[$];
  int           exp_cyc_q[$];
  logic [511:0] model_mem [WORDS];
  logic [63:0]  exp_rd = '0;
  logic [63:0]  exp_wr = '0;

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && s_readdatavalid) begin
      if (exp_q.size() == 0) begin
        check("rd_unexpected", 1, 0);
      end else begin
        check("rd_data", s_readdata, exp_q.pop_front());
        check("rd_cycle", cyc, exp_cyc_q.pop_front());
      end
    end
  end

  function automatic int eff_n(input int bc);
    if (bc == 0) return 1;
    if (bc > MAXB) return MAXB;
    return bc;
  endfunction

  function automatic logic [511:0] rand512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  task automatic model_write(input int w, input logic [511:0] d, input logic [63:0] be);
    for (int i = 0; i < 64; i++)
      if (be[i]) model_mem[w][8*i +: 8] = d[8*i +: 8];
  endtask

  // ---------------- driver tasks (entered and left at posedge + 1) ----------------
  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_accept(output int stalls);
    stalls = 0;
    @(negedge clk);
    while (s_waitrequest && stalls < 50) begin
      stalls++;
      @(negedge clk);
    end
    if (s_waitrequest) check("accept_timeout", 1, 0);
  endtask

  task automatic write_burst(input logic [63:0] addr, input logic [2:0] bc,
                             input logic [511:0] d0, input logic [63:0] be, input bit gaps);
    int n, ptr, stalls;
    n   = eff_n(int'(bc));
    ptr = int'(addr[DEPTH-1:0]);
    s_write = 1'b1; s_address = addr; s_burstcount = bc;
    s_writedata = d0; s_byteenable = be;
    wait_accept(stalls);
    check("wr_stall", stalls, 0);
    model_write(ptr, d0, be);
    exp_wr++;
    for (int k = 1; k < n; k++) begin
      @(posedge clk); #1;
      if (gaps && $urandom_range(0, 1) == 1) begin
        s_write = 1'b0;
        @(posedge clk); #1;
      end
      ptr = (ptr + 1) % WORDS;
      s_write = 1'b1; s_writedata = d0 + k;
      s_address = {$urandom, $urandom};
      s_burstcount = 3'($urandom_range(0, 7));
      @(negedge clk);
      check("wr_beat_wait", s_waitrequest, 0);
      model_write(ptr, d0 + k, be);
      exp_wr++;
    end
    @(posedge clk); #1;
    s_write = 1'b0; s_address = '0; s_burstcount = '0;
  endtask

  task automatic issue_read(input logic [63:0] addr, input logic [2:0] bc, output int stalls);
    int n, base;
    n    = eff_n(int'(bc));
    base = int'(addr[DEPTH-1:0]);
    s_read = 1'b1; s_address = addr; s_burstcount = bc;
    wait_accept(stalls);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(model_mem[(base + i) % WORDS]);
      exp_cyc_q.push_back(cyc + 2 + i);
      exp_rd++;
    end
    @(posedge clk); #1;
    s_read = 1'b0; s_address = '0; s_burstcount = '0;
    for (int i = 1; i < n; i++) begin
      @(negedge clk);
      check("rd_burst_wait", s_waitrequest, 1);
    end
    if (n > 1) begin @(posedge clk); #1; end
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 40) begin
      @(posedge clk); #1;
      t++;
    end
    if (exp_q.size() != 0) begin
      check("drain_timeout", exp_q.size(), 0);
      exp_q.delete();
      exp_cyc_q.delete();
    end
    idle(3);
  endtask

  task automatic check_counters();
    drain();
    check("rd_beats", rd_beats, exp_rd);
    check("wr_beats", wr_beats, exp_wr);
  endtask

  task automatic clear_counters();
    drain();
    cnt_clear = 1'b1;
    @(posedge clk); #1;
    cnt_clear = 1'b0;
    exp_rd = '0;
    exp_wr = '0;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int st;
    logic [63:0] full_be;
    full_be = '1;
    reset = 1'b1; s_address = '0; s_burstcount = '0; s_read = 1'b0; s_write = 1'b0;
    s_writedata = '0; s_byteenable = '0; cnt_clear = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_wait", s_waitrequest, 1);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("reset_state", dbg_state, 2'(IDLE));
    check("reset_wait_low", s_waitrequest, 0);
    check("reset_rdv", s_readdatavalid, 0);
    check("reset_rdata", s_readdata, 0);
    check("reset_rd_beats", rd_beats, 0);
    check("reset_wr_beats", wr_beats, 0);
    check("reset_flags", {addr_wrap, proto_err}, 0);
    @(posedge clk); #1;

    // burst write n=4 at 0x10 with data 1..4, then read it back as a burst
    write_burst(64'h10, 3'd4, 512'd1, full_be, 1'b0);
    issue_read(64'h10, 3'd4, st);
    check("rd_stall", st, 0);
    check_counters();

    // byte-enable merge on word 5
    write_burst(64'd5, 3'd1, 512'hFF, 64'h1, 1'b0);
    write_burst(64'd5, 3'd1, {64{8'hAA}}, ~64'h1, 1'b0);
    issue_read(64'd5, 3'd1, st);

    // eight back-to-back single reads
    for (int i = 0; i < 8; i++) begin
      issue_read(64'h10 + (i % 4), 3'd1, st);
      check("b2b_stall", st, 0);
    end
    check_counters();

    // address wrap inside a burst, with write gaps
    write_burst(WORDS - 2, 3'd4, rand512(), full_be, 1'b1);
    issue_read(WORDS - 2, 3'd4, st);
    drain();
    check("wrap_in_range", addr_wrap, 0);
    check("proto_clean", proto_err, 0);
    clear_counters();
    write_burst(WORDS + 3, 3'd1, rand512(), full_be, 1'b0);
    issue_read(WORDS + 3, 3'd1, st);
    drain();
    check("addr_wrap_set", addr_wrap, 1);

    // read+write together: write wins, read dropped
    clear_counters();
    s_read = 1'b1; s_write = 1'b1; s_address = 64'd20; s_burstcount = 3'd1;
    s_writedata = rand512(); s_byteenable = full_be;
    wait_accept(st);
    model_write(20, s_writedata, full_be);
    exp_wr++;
    @(posedge clk); #1;
    s_read = 1'b0; s_write = 1'b0;
    drain();
    check("rw_proto_err", proto_err, 1);
    check_counters();
    issue_read(64'd20, 3'd1, st);
    clear_counters();
    check("clear_flags", {addr_wrap, proto_err}, 0);

    // burstcount 7 clamps to 4 beats
    issue_read(64'h10, 3'd7, st);
    drain();
    check("clamp_proto_err", proto_err, 1);
    check_counters();

    // clear coinciding with a write beat: clear wins
    clear_counters();
    s_write = 1'b1; cnt_clear = 1'b1; s_address = 64'd30; s_burstcount = 3'd1;
    s_writedata = rand512(); s_byteenable = full_be;
    wait_accept(st);
    model_write(30, s_writedata, full_be);
    @(posedge clk); #1;
    s_write = 1'b0; cnt_clear = 1'b0;
    @(negedge clk);
    check("clear_wins_wr", wr_beats, 0);
    @(posedge clk); #1;
    issue_read(64'd30, 3'd1, st);
    check_counters();

    // random bursts with random byte enables and gaps
    for (int i = 0; i < 4; i++) begin
      logic [63:0] a;
      logic [2:0]  b;
      a = 64'($urandom_range(100, 900));
      b = 3'($urandom_range(1, 4));
      write_burst(a, b, rand512(), {$urandom, $urandom}, 1'b1);
      issue_read(a, b, st);
    end
    check_counters();
    check("proto_after_rand", proto_err, 0);

    // reset one cycle after accepting a read burst
    s_read = 1'b1; s_address = 64'h10; s_burstcount = 3'd4;
    wait_accept(st);
    @(posedge clk); #1;
    s_read = 1'b0; s_address = '0; s_burstcount = '0;
    reset = 1'b1;
    exp_q.delete();
    exp_cyc_q.delete();
    exp_rd = '0;
    exp_wr = '0;
    @(negedge clk);
    check("midrst_wait", s_waitrequest, 1);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("midrst_state", dbg_state, 2'(IDLE));
    check("midrst_wait_low", s_waitrequest, 0);
    check("midrst_rdv", s_readdatavalid, 0);
    check("midrst_rd_beats", rd_beats, 0);
    @(posedge clk); #1;
    idle(5);
    issue_read(64'h10, 3'd4, st);
    check_counters();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/avmm_burst_responder.md
# avmm_burst_responder

Avalon-MM pipelined slave, 512-bit word-addressed, backed by on-chip byte-enabled RAM; the responder end of the mspe data-input (read) and data-output (write) master ports. Used as the DRAM stand-in on m2/m3 in simulation and in FPGA self-test builds. It serves pipelined read bursts with fixed latency and accepts write bursts with per-byte enables. It also keeps beat counters and sticky protocol-error flags for the bench and CSR.

## Interface
- DEPTH, 10: RAM holds 2^DEPTH words of 512 bits.
- MAX_BURST, 4: largest legal burstcount; must be at most 7.
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- s_address  in  64  word address; the low DEPTH bits index the RAM.
- s_burstcount  in  3  beats per command; 0 is treated as 1.
- s_read  in  1  read command.
- s_write  in  1  write command / write data beat.
- s_writedata  in  512  write data.
- s_byteenable  in  64  per-byte write enable; bit i covers writedata[8i+7:8i].
- s_waitrequest  out  1  command/beat not accepted this cycle.
- s_readdata  out  512  read data.
- s_readdatavalid  out  1  s_readdata is valid.
- cnt_clear  in  1  synchronous clear of the counters and flags.
- rd_beats  out  64  read beats returned.
- wr_beats  out  64  write beats accepted.
- addr_wrap  out  1  sticky: an accessed address was ≥ 2^DEPTH.
- proto_err  out  1  sticky: a protocol violation was seen.

## Operation
- FSM states: IDLE, RBURST, WBURST.
- IDLE:
  - s_waitrequest=0.
  - A read with n=1 is issued at once and the FSM stays in IDLE. A read with n>1 issues beat 0, latches base+1 and n-1 remaining, and moves to RBURST.
  - A write writes beat 0 to s_address[DEPTH-1:0] under s_byteenable. With n>1, the FSM latches base+1 and n-1 remaining and moves to WBURST.
- RBURST:
  - s_waitrequest=1.
  - One beat is issued per cycle at consecutive addresses. After the last beat the FSM returns to IDLE. Commands presented meanwhile are stalled, not dropped.
- WBURST:
  - s_waitrequest=0.
  - Each cycle with s_write=1 writes one beat at the latched address, then increments the address and decrements the remaining count. s_address and s_burstcount are ignored.
  - Gaps with s_write=0 are allowed.
  - Leave for IDLE after the final beat.
  - s_read in WBURST: ignored, proto_err set.
- s_read and s_write both high in IDLE: the write is accepted, the read is dropped, proto_err set.
- burstcount > MAX_BURST: clamp to MAX_BURST, proto_err set.
- Address arithmetic is DEPTH-bit and wraps 2^DEPTH-1 → 0. addr_wrap is set if any bit above DEPTH-1 of an accepted s_address is nonzero.
- Counters:
  - rd_beats increments per readdatavalid beat; wr_beats increments per written beat. Both wrap at 2^64.
  - cnt_clear zeroes both counters, addr_wrap and proto_err. If cnt_clear coincides with a beat, the clear wins.

## Timing
- Read latency is 2: a beat issued in cycle T gives s_readdatavalid=1 in T+2. Single-beat reads accepted back-to-back sustain 1 beat/cycle.
- A burst of n accepted in cycle T returns beats in T+2 … T+n+1 with no gaps. s_waitrequest=1 in T+1 … T+n-1.
- Reads return strictly in issue order. The slave has no readdatavalid backpressure.
- Write-then-read: a write in cycle T is visible to a read issued in T+1 or later.
- Reset:
  - State IDLE. s_waitrequest=1 while reset is high, 0 from the first cycle after.
  - s_readdata=0, s_readdatavalid=0, counters=0, flags=0.
  - Reset mid-burst aborts the burst and flushes the 2-stage read pipeline, so no stale readdatavalid appears.
  - RAM contents are retained.

## Structure
- Package mspu_avmm_pkg holds the state enum (IDLE/RBURST/WBURST) and the constants DATA_W=512, BE_W=64, BURST_W=3. The mspe wrapper side imports the same package.
- Sub-module bram_be_512: simple dual-port RAM, 64 byte-lanes, registered read address plus registered output, giving the 2-cycle latency. The responder FSM, counters and valid pipeline live in the top.

## Test plan
- Write burst n=4 at base 0x10 with data k+1, all byte enables, then read burst n=4 at 0x10 → waitrequest low through the write beats; readdatavalid in T+2..T+5 with data 1,2,3,4; wr_beats=4; rd_beats=4.
- Write 0x00…FF to word 5 with byteenable=0x1, then a full write with byteenable=0x…FFFE and data all-0xAA, then read word 5 → byte0=0xFF, all other bytes 0xAA.
- 8 single reads accepted back-to-back → 8 consecutive readdatavalid cycles starting 2 cycles after the first accept, in order; waitrequest never high.
- Burst n=4 at address 2^DEPTH-2 → beats from words 2^DEPTH-2, 2^DEPTH-1, 0, 1. Separately, access address 2^DEPTH+3 → addr_wrap=1.
- s_read and s_write high together in IDLE, then burstcount=7 with MAX_BURST=4 → write performed, no read data, proto_err=1; clamped burst returns exactly 4 beats. cnt_clear → flags and counters 0.
- Reset asserted one cycle after accepting a read burst n=4 → no readdatavalid after reset; state IDLE; waitrequest=0 after reset deasserts; RAM data still readable.
